// File: rtl/ren_tile_queue.sv
// ren_tile_queue: tile work queue between the binner/subdivider and the
// rasterizer tile-fetch stage. Accepts one tile or a quad of four child tiles
// per cycle, stores them in FIFO order and presents the oldest entry
// show-ahead on o_tile.
//
// Optional feature macro: REN_TILE_QUEUE_STATS_EN
//   defined     -> o_hiwater (peak occupancy) and o_drop_cnt (rejected pushes,
//                  saturating) are live; cleared by reset only.
//   not defined -> both ports exist and are tied to 0.

package ren_tile_queue_pkg;
   // One unit of rasterizer work: tile coordinates in tile units.
   typedef struct packed {
      logic [11:0] tx;
      logic [11:0] ty;
   } tile_t;
endpackage

module ren_tile_queue
   import ren_tile_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_flush,
   input  logic                      i_push,
   input  logic                      i_push_quad,
   input  tile_t                     i_tile0,
   input  tile_t                     i_tile1,
   input  tile_t                     i_tile2,
   input  tile_t                     i_tile3,
   input  logic                      i_read,
   output tile_t                     o_tile,
   output logic                      o_empty,
   output logic                      o_full,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_overflow,
   output logic [$clog2(DEPTH):0]    o_hiwater,
   output logic [7:0]                o_drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage and registered control state.
   tile_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           overflow;

   // Next-state values and per-cycle decisions.
   logic [AW-1:0]  wr_ptr_nxt;
   logic [AW-1:0]  rd_ptr_nxt;
   logic [CW-1:0]  count_nxt;
   logic           overflow_nxt;
   logic [CW-1:0]  free_slots;
   logic [CW-1:0]  push_n;
   logic           push_ok;
   logic           push_rej;
   logic           pop_ok;
   logic [3:0]     wr_en;
   tile_t          tile_in [4];

   // Decide whether this cycle's push/pop are accepted; free space is taken
   // from the registered count, i.e. before any same-cycle pop.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      free_slots = CW'(DEPTH) - count;
      push_n     = i_push_quad ? CW'(4) : CW'(1);
      push_ok    = i_push && (free_slots >= push_n);
      push_rej   = i_push && !push_ok;
      pop_ok     = i_read && (count != '0);
      tile_in[0] = i_tile0;
      tile_in[1] = i_tile1;
      tile_in[2] = i_tile2;
      tile_in[3] = i_tile3;
      wr_en      = '0;
      if (push_ok && !i_flush) begin
         wr_en = i_push_quad ? 4'b1111 : 4'b0001;
      end
   end

   // Compute next pointers, occupancy and sticky overflow; flush wins over
   // push and pop.
   always_comb begin
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      count_nxt    = count;
      overflow_nxt = overflow;
      if (i_flush) begin
         wr_ptr_nxt   = '0;
         rd_ptr_nxt   = '0;
         count_nxt    = '0;
         overflow_nxt = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_nxt = wr_ptr + AW'(push_n);
         end
         if (pop_ok) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
         end
         count_nxt = count + (push_ok ? push_n : CW'(0)) - (pop_ok ? CW'(1) : CW'(0));
         if (push_rej) begin
            overflow_nxt = 1'b1;
         end
      end
   end

   // Register pointers, count and overflow flag.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of process ordering.
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
      end
   end

   // Write accepted tiles at wr_ptr..wr_ptr+3, wrapping across the array end.
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: the array is reset because o_tile must read 0 straight out of
      // reset; flush deliberately leaves the contents alone.
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
               mem[wr_ptr + AW'(k)] <= tile_in[k];
            end
         end
      end
   end

   // Status decode from registered state only.
   assign o_tile     = mem[rd_ptr];
   assign o_empty    = (count == '0);
   assign o_full     = (free_slots < CW'(4));
   assign o_count    = count;
   assign o_overflow = overflow;

`ifdef REN_TILE_QUEUE_STATS_EN
   logic [CW-1:0] hiwater;
   logic [7:0]    drop_cnt;

   // Track peak occupancy and count rejected pushes; flush does not clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hiwater  <= '0;
         drop_cnt <= '0;
      end else if (!i_flush) begin
         if (count_nxt > hiwater) begin
            hiwater <= count_nxt;
         end
         if (push_rej && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   assign o_hiwater  = hiwater;
   assign o_drop_cnt = drop_cnt;
`else
   assign o_hiwater  = '0;
   assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_ren_tile_queue.sv
// Self-checking bench for ren_tile_queue: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// queue-based reference model.
`timescale 1ns/1ps

module tb_ren_tile_queue;
   import ren_tile_queue_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rstn;
   logic          i_flush, i_push, i_push_quad, i_read;
   tile_t         i_tile0, i_tile1, i_tile2, i_tile3;
   tile_t         o_tile;
   logic          o_empty, o_full, o_overflow;
   logic [CW-1:0] o_count, o_hiwater;
   logic [7:0]    o_drop_cnt;

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   ren_tile_queue #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .i_flush    (i_flush),
      .i_push     (i_push),
      .i_push_quad(i_push_quad),
      .i_tile0    (i_tile0),
      .i_tile1    (i_tile1),
      .i_tile2    (i_tile2),
      .i_tile3    (i_tile3),
      .i_read     (i_read),
      .o_tile     (o_tile),
      .o_empty    (o_empty),
      .o_full     (o_full),
      .o_count    (o_count),
      .o_overflow (o_overflow),
      .o_hiwater  (o_hiwater),
      .o_drop_cnt (o_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   tile_t m_q[$];
   bit    m_ovf;
   int    m_hiwater;
   int    m_drops;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_q.delete();
         m_ovf     = 1'b0;
         m_hiwater = 0;
         m_drops   = 0;
      end else if (i_flush) begin
         m_q.delete();
         m_ovf = 1'b0;
      end else begin
         int  n;
         bit  accept, pop;
         tile_t t;
         n      = i_push_quad ? 4 : 1;
         accept = i_push && ((DEPTH - m_q.size()) >= n);
         pop    = i_read && (m_q.size() != 0);
         if (pop) t = m_q.pop_front();
         if (accept) begin
            m_q.push_back(i_tile0);
            if (i_push_quad) begin
               m_q.push_back(i_tile1);
               m_q.push_back(i_tile2);
               m_q.push_back(i_tile3);
            end
         end else if (i_push) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
         end
         if (m_q.size() > m_hiwater) m_hiwater = m_q.size();
      end
   end

   // ---------------- per-cycle comparison ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("empty", 64'(o_empty), 64'(m_q.size() == 0));
         check("full", 64'(o_full), 64'((DEPTH - m_q.size()) < 4));
         check("count", 64'(o_count), 64'(m_q.size()));
         check("overflow", 64'(o_overflow), 64'(m_ovf));
         if (m_q.size() != 0) check("tile", 64'(o_tile), 64'(m_q[0]));
`ifdef REN_TILE_QUEUE_STATS_EN
         check("hiwater", 64'(o_hiwater), 64'(m_hiwater));
         check("drop_cnt", 64'(o_drop_cnt), 64'(m_drops));
`else
         check("hiwater_tied", 64'(o_hiwater), 64'd0);
         check("drop_cnt_tied", 64'(o_drop_cnt), 64'd0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   // Drive one cycle of inputs at the falling edge; return at the next falling
   // edge, when the resulting state is visible.
   task automatic cyc(input bit flush, input bit push, input bit quad, input bit rd,
                      input tile_t t0, input tile_t t1, input tile_t t2, input tile_t t3);
      i_flush = flush; i_push = push; i_push_quad = quad; i_read = rd;
      i_tile0 = t0; i_tile1 = t1; i_tile2 = t2; i_tile3 = t3;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   task automatic push1(input tile_t t);
      cyc(0, 1, 0, 0, t, '0, '0, '0);
   endtask

   task automatic pushq(input tile_t a, input tile_t b, input tile_t c, input tile_t d);
      cyc(0, 1, 1, 0, a, b, c, d);
   endtask

   task automatic pop_expect(input string name, input tile_t exp);
      check(name, 64'(o_tile), 64'(exp));
      cyc(0, 0, 0, 1, '0, '0, '0, '0);
   endtask

   function automatic tile_t mk(input int v);
      return tile_t'(24'(v));
   endfunction

   function automatic tile_t rnd_tile();
      return tile_t'(24'($urandom));
   endfunction

   initial begin
      tile_t a, b, c, d, e, f, g, h, x;
      a = mk(24'h00A001); b = mk(24'h00B002); c = mk(24'h00C003); d = mk(24'h00D004);
      e = mk(24'h0E0014); f = mk(24'h0F0015); g = mk(24'h010016); h = mk(24'h011017);
      x = mk(24'h5A5A5A);

      rstn = 1'b0;
      i_flush = 0; i_push = 0; i_push_quad = 0; i_read = 0;
      i_tile0 = '0; i_tile1 = '0; i_tile2 = '0; i_tile3 = '0;
      repeat (3) @(negedge clk);
      check("rst_empty", 64'(o_empty), 64'd1);
      check("rst_full", 64'(o_full), 64'd0);
      check("rst_count", 64'(o_count), 64'd0);
      check("rst_overflow", 64'(o_overflow), 64'd0);
      check("rst_tile", 64'(o_tile), 64'd0);
      rstn = 1'b1;
      cmp_en = 1'b1;
      idle();

      // Quad push, visible next cycle, popped in order.
      pushq(a, b, c, d);
      check("quad_empty", 64'(o_empty), 64'd0);
      check("quad_count", 64'(o_count), 64'd4);
      check("quad_head", 64'(o_tile), 64'(a));
      pop_expect("pop_a", a);
      pop_expect("pop_b", b);
      pop_expect("pop_c", c);
      pop_expect("pop_d", d);
      check("drained_empty", 64'(o_empty), 64'd1);

      // Fill and overflow.
      for (int i = 0; i < 4; i++) pushq(mk(16 + 4*i), mk(17 + 4*i), mk(18 + 4*i), mk(19 + 4*i));
      check("fill_count", 64'(o_count), 64'd16);
      check("fill_full", 64'(o_full), 64'd1);
      check("fill_no_ovf", 64'(o_overflow), 64'd0);
      push1(mk(24'hBAD));
      check("ovf_flag", 64'(o_overflow), 64'd1);
      check("ovf_count", 64'(o_count), 64'd16);
`ifdef REN_TILE_QUEUE_STATS_EN
      check("ovf_drop_cnt", 64'(o_drop_cnt), 64'd1);
`endif

      // Push/pop collision at count 13: quad rejected, pop still happens.
      repeat (3) cyc(0, 0, 0, 1, '0, '0, '0, '0);
      check("pre_collide_count", 64'(o_count), 64'd13);
      check("pre_collide_full", 64'(o_full), 64'd1);
      cyc(0, 1, 1, 1, mk(1), mk(2), mk(3), mk(4));
      check("collide_count", 64'(o_count), 64'd12);
      check("collide_head", 64'(o_tile), 64'(mk(20)));

      // Wrap-around: flush, push/pop 14 singles, then a quad spanning 14..1.
      cyc(1, 0, 0, 0, '0, '0, '0, '0);
      check("flush_ovf_clear", 64'(o_overflow), 64'd0);
      for (int i = 0; i < 14; i++) push1(mk(100 + i));
      check("pre_wrap_count", 64'(o_count), 64'd14);
      for (int i = 0; i < 14; i++) pop_expect("pop_single", mk(100 + i));
      pushq(e, f, g, h);
      check("wrap_count", 64'(o_count), 64'd4);
      pop_expect("pop_e", e);
      pop_expect("pop_f", f);
      pop_expect("pop_g", g);
      pop_expect("pop_h", h);

      // Read held while empty, then a push is visible and popped.
      repeat (5) cyc(0, 0, 0, 1, '0, '0, '0, '0);
      check("rd_empty_count", 64'(o_count), 64'd0);
      push1(x);
      check("x_head", 64'(o_tile), 64'(x));
      check("x_count", 64'(o_count), 64'd1);
      pop_expect("pop_x", x);
      check("x_gone", 64'(o_empty), 64'd1);

      // Flush beats a same-cycle quad push and pop; overflow cleared too.
      for (int i = 0; i < 4; i++) pushq(mk(200), mk(201), mk(202), mk(203));
      push1(mk(204));
      check("pre_flush_ovf", 64'(o_overflow), 64'd1);
      cyc(1, 1, 1, 1, mk(1), mk(2), mk(3), mk(4));
      check("flush_count", 64'(o_count), 64'd0);
      check("flush_empty", 64'(o_empty), 64'd1);
      check("flush_ovf", 64'(o_overflow), 64'd0);

      // Randomized traffic with varying push/read bias.
      for (int ph = 0; ph < 6; ph++) begin
         int push_pct, rd_pct;
         push_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 50 : 25;
         rd_pct   = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 50 : 85;
         for (int i = 0; i < 300; i++) begin
            cyc($urandom_range(99) < 2,
                $urandom_range(99) < push_pct,
                $urandom_range(1),
                $urandom_range(99) < rd_pct,
                rnd_tile(), rnd_tile(), rnd_tile(), rnd_tile());
         end
      end

      // Asynchronous reset mid-stream, during a quad push and pop.
      for (int i = 0; i < 3; i++) pushq(rnd_tile(), rnd_tile(), rnd_tile(), rnd_tile());
      i_flush = 0; i_push = 1; i_push_quad = 1; i_read = 1;
      #3;
      rstn = 1'b0;
      #1;
      check("arst_empty", 64'(o_empty), 64'd1);
      check("arst_full", 64'(o_full), 64'd0);
      check("arst_count", 64'(o_count), 64'd0);
      check("arst_overflow", 64'(o_overflow), 64'd0);
      check("arst_tile", 64'(o_tile), 64'd0);
      check("arst_hiwater", 64'(o_hiwater), 64'd0);
      check("arst_drop_cnt", 64'(o_drop_cnt), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      idle();
      pushq(a, b, c, d);
      check("post_rst_head", 64'(o_tile), 64'(a));
      repeat (2) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
